// File: rtl/write_address_translator_pipelined.sv
// Pipelined write address translator: plain (drop MSBs) or split (lane slice + base) mode.
// Optional saturating out-of-range counter enabled by WRITE_ADDR_TRANSLATE_ERROR_COUNT_EN.
module write_address_translator_pipelined #(
   parameter int WRITE_ADDR_WIDTH       = 12,
   parameter int WRITE_ADDR_WIDTH_LOCAL = 10,
   parameter int SPLIT_WAYS             = 2,
   parameter int LANE_INDEX             = 0,
   parameter int PIPE_DEPTH             = 2
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              mode_wren,
   input  logic                              mode_split,
   input  logic [WRITE_ADDR_WIDTH_LOCAL-1:0] mode_base,
   input  logic                              write_en_in,
   input  logic [WRITE_ADDR_WIDTH-1:0]       write_addr,
   output logic                              write_en_out,
   output logic [WRITE_ADDR_WIDTH_LOCAL-1:0] write_addr_translated,
   output logic                              out_of_range
`ifdef WRITE_ADDR_TRANSLATE_ERROR_COUNT_EN
   ,
   input  logic                              error_count_clear,
   output logic [15:0]                       error_count
`endif
);

   localparam int AW = WRITE_ADDR_WIDTH;
   localparam int LW = WRITE_ADDR_WIDTH_LOCAL;
   localparam int S  = WRITE_ADDR_WIDTH / SPLIT_WAYS;

   logic          mode_split_q, mode_split_d;
   logic [LW-1:0] mode_base_q, mode_base_d;

   logic [LW-1:0] plain_addr;
   logic          dropped_nz;
   logic [S-1:0]  lane_slice;
   logic [LW-1:0] split_addr;

   logic [LW-1:0] t_addr;
   logic          t_oor;
   logic          t_en;

   logic [LW-1:0]         addr_q [PIPE_DEPTH];
   logic [LW-1:0]         addr_d [PIPE_DEPTH];
   logic [PIPE_DEPTH-1:0] en_q, en_d;
   logic [PIPE_DEPTH-1:0] oor_q, oor_d;

   generate
      if (AW > LW) begin : g_drop
         assign plain_addr = write_addr[LW-1:0];
         assign dropped_nz = |write_addr[AW-1:LW];
      end else begin : g_no_drop
         assign plain_addr = LW'(write_addr);
         assign dropped_nz = 1'b0;
      end
   endgenerate

   assign lane_slice = write_addr[LANE_INDEX*S +: S];
   // Sum is truncated to LW bits, so the carry out is discarded by design.
   assign split_addr = LW'(lane_slice) + mode_base_q;

   always_comb begin
      mode_split_d = mode_split_q;
      mode_base_d  = mode_base_q;
      if (mode_wren) begin
         mode_split_d = mode_split;
         mode_base_d  = mode_base;
      end
   end

   // Stage-1 translation uses the registered mode, so a same-edge mode write affects only later inputs.
   always_comb begin
      t_addr = plain_addr;
      t_oor  = 1'b0;
      if (mode_split_q) begin
         t_addr = split_addr;
      end else begin
         t_oor = write_en_in & dropped_nz;
      end
      t_en = write_en_in & ~t_oor;
   end

   always_comb begin
      addr_d[0] = t_addr;
      en_d      = '0;
      oor_d     = '0;
      en_d[0]   = t_en;
      oor_d[0]  = t_oor;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
         addr_d[i] = addr_q[i-1];
         en_d[i]   = en_q[i-1];
         oor_d[i]  = oor_q[i-1];
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mode_split_q <= 1'b0;
         mode_base_q  <= '0;
         en_q         <= '0;
         oor_q        <= '0;
         for (int i = 0; i < PIPE_DEPTH; i++) begin
            addr_q[i] <= '0;
         end
      end else begin
         mode_split_q <= mode_split_d;
         mode_base_q  <= mode_base_d;
         en_q         <= en_d;
         oor_q        <= oor_d;
         for (int i = 0; i < PIPE_DEPTH; i++) begin
            addr_q[i] <= addr_d[i];
         end
      end
   end

   assign write_addr_translated = addr_q[PIPE_DEPTH-1];
   assign write_en_out          = en_q[PIPE_DEPTH-1];
   assign out_of_range          = oor_q[PIPE_DEPTH-1];

`ifdef WRITE_ADDR_TRANSLATE_ERROR_COUNT_EN
   logic [15:0] err_cnt_q, err_cnt_d;

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (error_count_clear) begin
         err_cnt_d = '0;
      end else if (oor_q[PIPE_DEPTH-1] && (err_cnt_q != 16'hFFFF)) begin
         err_cnt_d = err_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         err_cnt_q <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign error_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_write_address_translator_pipelined.sv
// Scoreboard bench for write_address_translator_pipelined (LANE_INDEX=1) with a behavioural model.
// Error-counter checks are compiled in when WRITE_ADDR_TRANSLATE_ERROR_COUNT_EN is defined.
module tb_write_address_translator_pipelined;

   localparam int AW   = 12;
   localparam int LW   = 10;
   localparam int WAYS = 2;
   localparam int LANE = 1;
   localparam int D    = 2;
   localparam int S    = AW / WAYS;

   logic          clock;
   logic          reset;
   logic          mode_wren;
   logic          mode_split;
   logic [LW-1:0] mode_base;
   logic          write_en_in;
   logic [AW-1:0] write_addr;
   logic          write_en_out;
   logic [LW-1:0] write_addr_translated;
   logic          out_of_range;
`ifdef WRITE_ADDR_TRANSLATE_ERROR_COUNT_EN
   logic          err_clr;
   logic [15:0]   error_count;
`endif

   logic [LW+1:0] exp_q[$];
   int            n_checks;
   int            n_fail;
   int            n_edges;
   logic          m_split;
   logic [LW-1:0] m_base;

   write_address_translator_pipelined #(
      .WRITE_ADDR_WIDTH      (AW),
      .WRITE_ADDR_WIDTH_LOCAL(LW),
      .SPLIT_WAYS            (WAYS),
      .LANE_INDEX            (LANE),
      .PIPE_DEPTH            (D)
   ) dut (
      .clock                (clock),
      .reset                (reset),
      .mode_wren            (mode_wren),
      .mode_split           (mode_split),
      .mode_base            (mode_base),
      .write_en_in          (write_en_in),
      .write_addr           (write_addr),
      .write_en_out         (write_en_out),
      .write_addr_translated(write_addr_translated),
      .out_of_range         (out_of_range)
`ifdef WRITE_ADDR_TRANSLATE_ERROR_COUNT_EN
      ,
      .error_count_clear    (err_clr),
      .error_count          (error_count)
`endif
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   // Reference: {write_en_out, out_of_range, address} from plain arithmetic.
   function automatic logic [LW+1:0] model(input logic [AW-1:0] a, input logic en,
                                           input logic split, input logic [LW-1:0] base);
      int unsigned ai, res, slice;
      logic        oor;
      ai  = a;
      oor = 1'b0;
      if (split) begin
         slice = (ai >> (LANE * S)) % (1 << S);
         res   = (slice + base) % (1 << LW);
      end else begin
         res = ai % (1 << LW);
         oor = en && ((ai >> LW) != 0);
      end
      return {en && !oor, oor, LW'(res)};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=0x%0h required=0x%0h time=%0t", name, act, req, $time);
      end
   endtask

   // driver: set inputs for the next rising edge, record expectation, advance one cycle
   task automatic drive(input logic wren, input logic split, input logic [LW-1:0] base,
                        input logic en, input logic [AW-1:0] addr);
      mode_wren   = wren;
      mode_split  = split;
      mode_base   = base;
      write_en_in = en;
      write_addr  = addr;
      exp_q.push_back(model(addr, en, m_split, m_base));
      if (wren) begin
         m_split = split;
         m_base  = base;
      end
      @(negedge clock);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, 1'b0, AW'($urandom_range(0, 4095)));
   endtask

   // monitor
   initial begin
      n_edges = 0;
      forever begin
         @(posedge clock);
         if (reset) n_edges = 0;
         else n_edges++;
      end
   end

   initial begin
      logic [LW+1:0] e;
      forever begin
         @(negedge clock);
         if (!reset) begin
            if (n_edges >= D) begin
               if (exp_q.size() == 0) begin
                  chk("scoreboard_underflow", 32'd0, 32'd1);
               end else begin
                  e = exp_q.pop_front();
                  chk("output", {write_en_out, out_of_range, write_addr_translated}, e);
               end
            end else begin
               chk("post_reset_idle", {write_en_out, out_of_range, write_addr_translated}, '0);
            end
         end
      end
   end

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      m_split     = 1'b0;
      m_base      = '0;
      reset       = 1'b1;
      mode_wren   = 1'b0;
      mode_split  = 1'b0;
      mode_base   = '0;
      write_en_in = 1'b0;
      write_addr  = '0;
`ifdef WRITE_ADDR_TRANSLATE_ERROR_COUNT_EN
      err_clr     = 1'b0;
`endif
      #12;
      chk("reset_outputs", {write_en_out, out_of_range, write_addr_translated}, '0);
`ifdef WRITE_ADDR_TRANSLATE_ERROR_COUNT_EN
      chk("reset_error_count", error_count, 0);
`endif
      @(negedge clock);
      reset = 1'b0;

      // plain in range, plain out of range
      drive(1'b0, 1'b0, '0, 1'b1, 12'h1A5);
      drive(1'b0, 1'b0, '0, 1'b1, 12'hC05);
      drive(1'b0, 1'b0, '0, 1'b0, 12'hC05);
      // mode write on the same edge as a plain input, split input right behind it
      drive(1'b1, 1'b1, 10'h3F0, 1'b1, 12'h1A5);
      drive(1'b0, 1'b0, '0, 1'b1, 12'hABC);
      drive(1'b0, 1'b0, '0, 1'b1, 12'hFFF);
      // mode change while split entries are in flight
      drive(1'b1, 1'b1, 10'h001, 1'b1, 12'hFC0);
      drive(1'b1, 1'b0, '0, 1'b1, 12'hFC0);
      drive(1'b1, 1'b1, 10'h3F0, 1'b1, 12'h3FF);
      drive(1'b0, 1'b0, '0, 1'b1, 12'h0C0);

      // asynchronous reset with two writes in flight
      drive(1'b0, 1'b0, '0, 1'b1, 12'hABC);
      drive(1'b0, 1'b0, '0, 1'b1, 12'h7C1);
      @(posedge clock);
      #2 reset = 1'b1;
      #1;
      chk("async_reset_outputs", {write_en_out, out_of_range, write_addr_translated}, '0);
      exp_q.delete();
      m_split     = 1'b0;
      m_base      = '0;
      write_en_in = 1'b0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      // mode must be back to plain: this one is out of range
      drive(1'b0, 1'b0, '0, 1'b1, 12'hC05);
      drive(1'b0, 1'b0, '0, 1'b1, 12'h3FF);
      idle(D);

`ifdef WRITE_ADDR_TRANSLATE_ERROR_COUNT_EN
      drive(1'b0, 1'b0, '0, 1'b0, '0);
      err_clr = 1'b1;
      drive(1'b0, 1'b0, '0, 1'b0, '0);
      err_clr = 1'b0;
      chk("error_count_cleared", error_count, 0);
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, '0, 1'b1, 12'hC05);
      idle(D + 1);
      chk("error_count_three", error_count, 3);
      drive(1'b0, 1'b0, '0, 1'b1, 12'hC05);
      drive(1'b0, 1'b0, '0, 1'b0, '0);
      err_clr = 1'b1;
      drive(1'b0, 1'b0, '0, 1'b0, '0);
      err_clr = 1'b0;
      drive(1'b0, 1'b0, '0, 1'b0, '0);
      chk("error_count_clear_priority", error_count, 0);
`endif

      // randomized traffic with occasional mode rewrites
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)), LW'($urandom_range(0, 1023)),
               $urandom_range(0, 3) != 0, AW'($urandom_range(0, 4095)));
      end
      idle(D);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/write_address_translator_pipelined.md
Name: write_address_translator_pipelined

Overview:
- Pipelined, mode-programmable successor to the two-way write address splitter.
- Translates a wide write address into one memory's local write address space.
- Modes:
  - Plain: drop MSBs.
  - Split: select one of SPLIT_WAYS equal address slices, zero-pad it, then add a programmable base.
- Sits between the instruction decode write-address stage and each memory's write port. One instance per memory, with LANE_INDEX set statically. Write enable is carried alongside the address and suppressed for out-of-range plain-mode writes.

Parameters:
- WRITE_ADDR_WIDTH, 12, width of the global write address; must be divisible by SPLIT_WAYS.
- WRITE_ADDR_WIDTH_LOCAL, 10, width of the local memory write address; must be >= WRITE_ADDR_WIDTH/SPLIT_WAYS.
- SPLIT_WAYS, 2, number of equal slices in split mode; power of two, 2..8.
- LANE_INDEX, 0, slice selected in split mode; 0 = least-significant slice, range 0..SPLIT_WAYS-1.
- PIPE_DEPTH, 2, register stages from input to output; range 1..4.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- mode_wren  in  1  loads mode_split and mode_base on this edge.
- mode_split  in  1  0 = plain, 1 = split.
- mode_base  in  WRITE_ADDR_WIDTH_LOCAL  base added in split mode.
- write_en_in  in  1  write enable accompanying write_addr.
- write_addr  in  WRITE_ADDR_WIDTH  global write address.
- write_en_out  out  1  delayed write enable; forced 0 when out of range.
- write_addr_translated  out  WRITE_ADDR_WIDTH_LOCAL  translated local address.
- out_of_range  out  1  pulse aligned with the output: a plain-mode write had nonzero dropped MSBs.

Behaviour:
- Reset, asynchronous and immediate:
  - All pipeline stages cleared; write_en_out=0, write_addr_translated=0, out_of_range=0.
  - Mode register cleared to plain with base 0.
  - Reset mid-stream discards all in-flight writes; no write_en_out pulse may emerge afterwards from pre-reset inputs.
- Mode register:
  - Updated on the clock edge where mode_wren=1.
  - An input presented on that same edge uses the OLD mode; the new mode applies from the next cycle's input.
  - Each in-flight entry carries the mode and base captured at entry, so a mode change never alters an address already in the pipeline.
- Translation, with S = WRITE_ADDR_WIDTH/SPLIT_WAYS:
  - Plain mode:
    - Output = write_addr[WRITE_ADDR_WIDTH_LOCAL-1:0].
    - out_of_range = write_en_in AND (write_addr[WRITE_ADDR_WIDTH-1:WRITE_ADDR_WIDTH_LOCAL] != 0).
    - If WRITE_ADDR_WIDTH <= WRITE_ADDR_WIDTH_LOCAL, there are no dropped bits: zero-extend the address and out_of_range is never set.
  - Split mode:
    - Slice = write_addr[(LANE_INDEX+1)*S-1 : LANE_INDEX*S].
    - Output = (zero-padded slice + base) modulo 2^WRITE_ADDR_WIDTH_LOCAL; the sum wraps and the carry is discarded.
    - out_of_range is always 0.
- Enable gating:
  - write_en_out = write_en_in AND NOT out_of_range, delayed.
  - When write_en_in=0, the address still propagates and out_of_range=0.
- Latency:
  - Exactly PIPE_DEPTH cycles from input edge to output for address, enable and flag together.
  - Full throughput: one translation per cycle, no stalls, no backpressure.
- Combinational path: translation and addition occur in stage 1; remaining stages are pure delay.

Optional Feature:
- Macro: WRITE_ADDR_TRANSLATE_ERROR_COUNT_EN.
- Defined:
  - Adds output port error_count [15:0], reset to 0.
  - Increments on each cycle where out_of_range is asserted at the output, saturating at 0xFFFF.
  - Adds input error_count_clear (1 bit), which zeroes the counter synchronously. Clear has priority over a simultaneous increment.
- Undefined: neither port exists and no counter logic is present.

Test Plan (defaults unless noted; LANE_INDEX=1, so S=6):
- Plain, write_en_in=1, write_addr=0x1A5 -> after 2 cycles: write_addr_translated=0x1A5, write_en_out=1, out_of_range=0.
- Plain, write_addr=0xC05, write_en_in=1 -> after 2 cycles: write_addr_translated=0x005, write_en_out=0, out_of_range=1.
- mode_wren=1, mode_split=1, mode_base=0x3F0; next cycle write_addr=0xABC -> slice 0x2A, sum 0x41A wraps, so after 2 cycles write_addr_translated=0x01A, write_en_out=1.
- Back-to-back: input 0x1A5 on the edge where mode_wren switches to split, then 0xABC next cycle -> outputs on consecutive cycles are 0x1A5 (plain) then 0x01A (split); no bubble.
- Reset asserted asynchronously while two valid writes are in flight -> outputs 0 immediately and mode reverts to plain; after release, no write_en_out pulse appears.
- With WRITE_ADDR_TRANSLATE_ERROR_COUNT_EN:
  - 3 out-of-range plain writes -> error_count=3.
  - error_count_clear coincident with a 4th out-of-range write -> error_count=0.
